// File: rtl/pipeline_stall_ctrl.sv
// Pipeline latch enable/flush sequencer: stalls, branch redirects, halt drain, stall watchdog.
// Optional perf counters (stall_cnt/flush_cnt) are built when PERF_COUNTERS_EN is defined.
module pipeline_stall_ctrl #(
   parameter int WDOG_CYC = 64
`ifdef PERF_COUNTERS_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic CLK,
   input  logic RST,
   input  logic ihit,
   input  logic dhit,
   input  logic mem_req,
   input  logic hazard,
   input  logic branch,
   input  logic jump,
   input  logic halt_id,
   input  logic halt_wb,
   output logic pc_en,
   output logic ifid_en,
   output logic ifid_flush,
   output logic idex_en,
   output logic idex_flush,
   output logic exmem_en,
   output logic memwb_en,
   output logic halt_out,
   output logic err_stall
`ifdef PERF_COUNTERS_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam int WD_W = $clog2(WDOG_CYC + 1);

   typedef enum logic [1:0] {RUN, REDIRECT, DRAIN, HALTED} state_t;

   state_t          state_q, state_d;
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            halt_q, halt_d;
   logic            err_q, err_d;
   logic            dstall, rule2;
   logic            pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
   logic            exmem_en_c, memwb_en_c;

   assign dstall = mem_req & ~dhit;

   always_comb begin
      state_d      = state_q;
      rule2        = 1'b0;
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      ifid_flush_c = 1'b0;
      idex_en_c    = 1'b0;
      idex_flush_c = 1'b0;
      exmem_en_c   = 1'b0;
      memwb_en_c   = 1'b0;
      case (state_q)
         RUN, REDIRECT: begin
            if (!dstall) begin
               idex_en_c  = 1'b1;
               exmem_en_c = 1'b1;
               memwb_en_c = 1'b1;
               if (hazard && !branch && !jump) begin
                  rule2        = 1'b1;
                  idex_flush_c = 1'b1;
               end else if (branch || jump) begin
                  pc_en_c      = 1'b1;
                  ifid_en_c    = 1'b1;
                  ifid_flush_c = 1'b1;
                  state_d      = ihit ? RUN : REDIRECT;
               end else if (!ihit) begin
                  ifid_en_c    = 1'b1;
                  ifid_flush_c = 1'b1;
               end else begin
                  pc_en_c   = 1'b1;
                  ifid_en_c = 1'b1;
               end
               // The first word returned after a redirect is from the old path.
               if (state_q == REDIRECT) begin
                  ifid_flush_c = ifid_en_c;
                  if (ihit) state_d = RUN;
               end
               if (halt_id) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!dstall) begin
               ifid_en_c    = 1'b1;
               ifid_flush_c = 1'b1;
               idex_en_c    = 1'b1;
               exmem_en_c   = 1'b1;
               memwb_en_c   = 1'b1;
            end
            if (halt_wb) state_d = HALTED;
         end
         HALTED: state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      wdog_d = '0;
      if (rule2) wdog_d = (wdog_q == WD_W'(WDOG_CYC)) ? wdog_q : wdog_q + WD_W'(1);
      err_d  = err_q | (wdog_d == WD_W'(WDOG_CYC));
      halt_d = halt_q | ((state_q == DRAIN) & halt_wb);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= RUN;
         wdog_q  <= '0;
         halt_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
         halt_q  <= halt_d;
         err_q   <= err_d;
      end
   end

   assign pc_en      = pc_en_c & ~RST;
   assign ifid_en    = ifid_en_c & ~RST;
   assign ifid_flush = ifid_flush_c & ~RST;
   assign idex_en    = idex_en_c & ~RST;
   assign idex_flush = idex_flush_c & ~RST;
   assign exmem_en   = exmem_en_c & ~RST;
   assign memwb_en   = memwb_en_c & ~RST;
   assign halt_out   = halt_q;
   assign err_stall  = err_q;

`ifdef PERF_COUNTERS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   // A data freeze counts as a stall in any live state, including DRAIN.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q != HALTED && (rule2 || dstall)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if ((ifid_flush_c && ifid_en_c) || (idex_flush_c && idex_en_c))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
